fifo_tx_scheduler: RTL and testbench

- Sequences the 16-entry byte FIFO into the UART/IrDA transmitter.
- Watches the FIFO empty flag and pops one byte at a time, allowing for the registered RAM read latency.
- Hands each byte to the transmitter with a start/busy handshake, then enforces a programmable inter-frame gap.
- Sits between the FIFO controller and the TX serializer; the only block that drives the FIFO read strobe.

---
 rtl/fifo_tx_scheduler_pkg.sv | 25 ++
 rtl/fifo_tx_scheduler_tx_gap_timer.sv | 28 ++
 rtl/fifo_tx_scheduler.sv | 108 ++++++++++
 tb/tb_fifo_tx_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_tx_scheduler_pkg.sv
// Shared types and defaults for the FIFO-to-transmitter scheduler.
// The state encoding is fixed at 3 bits so it can be probed and compared across revisions.
package fifo_tx_scheduler_pkg;

  localparam int DEFAULT_GAP_CYCLES  = 16;
  localparam int DEFAULT_ACK_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE    = 3'd1,
    LOAD      = 3'd2,
    START     = 3'd3,
    WAIT_ACK  = 3'd4,
    WAIT_DONE = 3'd5,
    GAP       = 3'd6
  } state_t;

  // One timer serves both the ack timeout and the gap, so it must hold the larger reload value.
  function automatic int timer_width(input int gap_cycles, input int ack_timeout);
    int max_val;
    max_val = (gap_cycles > ack_timeout) ? gap_cycles : ack_timeout;
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_tx_scheduler_tx_gap_timer.sv
// Loadable down-counter shared by the ack-timeout and inter-frame-gap phases.
// The counter stops at zero; done is asserted while it sits there.
module tx_gap_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/fifo_tx_scheduler.sv
// Pops one byte at a time from the TX FIFO, hands it to the serializer with a
// start/busy handshake and then holds off for a programmable inter-frame gap.
module fifo_tx_scheduler
  import fifo_tx_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear_err,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  active,
  output logic                  ack_error,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  localparam int TW = timer_width(GAP_CYCLES, ACK_TIMEOUT);
  localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  state_t          state;
  state_t          state_next;
  logic            timer_load;
  logic [TW-1:0]   timer_value;
  logic            timer_done;
  logic            timeout;
  logic            frame_done;

  tx_gap_timer #(.WIDTH(TW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    timer_load  = 1'b0;
    timer_value = GAP_LOAD;
    timeout     = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE:   if (enable && !fifo_empty) state_next = SETTLE;
      SETTLE: state_next = LOAD;
      LOAD:   state_next = START;
      START: begin
        timer_load  = 1'b1;
        timer_value = ACK_LOAD;
        state_next  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timer_done) begin
          // The byte is dropped: flag the error but still honour the gap.
          timeout    = 1'b1;
          timer_load = 1'b1;
          state_next = HAS_GAP ? GAP : IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          frame_done = 1'b1;
          timer_load = 1'b1;
          state_next = HAS_GAP ? GAP : IDLE;
        end
      end
      GAP:     if (timer_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      tx_data     <= '0;
      ack_error   <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_next;
      if (state == LOAD) tx_data <= fifo_data;
      if (timeout) begin
        ack_error <= 1'b1;
      end else if (clear_err) begin
        ack_error <= 1'b0;
      end
      if (frame_done) frame_count <= frame_count + CNT_WIDTH'(1);
    end
  end

  // Strobes decode the state register alone, so they are glitch-free and input-independent.
  assign fifo_rd  = (state == LOAD);
  assign tx_start = (state == START);
  assign active   = (state != IDLE);

endmodule

// File: tb/tb_fifo_tx_scheduler.sv
// Self-checking bench for fifo_tx_scheduler: behavioural FIFO and transmitter models,
// a byte scoreboard checked on every tx_start, a latency vector table and corner-case sequences.
module tb_fifo_tx_scheduler;

  localparam int DW    = 8;
  localparam int G_CYC = 3;
  localparam int A_TO  = 6;
  localparam int CW    = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          clear_err;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd;
  logic          tx_busy;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          active;
  logic          ack_error;
  logic [CW-1:0] frame_count;

  always #5 clock = ~clock;

  fifo_tx_scheduler #(
    .DATA_WIDTH  (DW),
    .GAP_CYCLES  (G_CYC),
    .ACK_TIMEOUT (A_TO),
    .CNT_WIDTH   (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .clear_err   (clear_err),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_rd     (fifo_rd),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .active      (active),
    .ack_error   (ack_error),
    .frame_count (frame_count)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            busy_len;
    int            exp_rd_off;
    int            exp_start_off;
    int            exp_idle_off;
  } vec_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  bit            prev_rd    = 1'b0;
  int            busy_cnt   = 0;
  bit            busy_en    = 1'b1;
  int            busy_len   = 3;
  int            rd_count   = 0;
  int            start_count = 0;
  int            last_start = 0;
  int            prev_start = 0;
  int            exp_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // One clock: models update on the falling edge, away from the DUT's sampling edge.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (prev_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (fifo_rd) begin
      rd_count++;
      if (fifo_q.size() == 0) fail_now("pop_while_empty");
    end
    prev_rd = fifo_rd;
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      if (tx_start) begin
        start_count++;
        prev_start = last_start;
        last_start = cyc;
        if (busy_en) busy_cnt = busy_len + 1;
        if (exp_q.size() == 0) fail_now("unexpected_tx_start");
        else check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    tx_busy    = (busy_cnt > 0);
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_start(input string name);
    int target = start_count + 1;
    int k = 0;
    while (start_count < target && k < 200) begin
      tick();
      k++;
    end
    if (start_count < target) fail_now(name);
  endtask

  task automatic run_frames(input int target, input int bound, input string name);
    int k = 0;
    while ((start_count < target || active) && k < bound) begin
      tick();
      k++;
    end
    if (k >= bound) fail_now(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fifo_rd"},     32'(fifo_rd),     32'd0);
    check({tag, "_tx_start"},    32'(tx_start),    32'd0);
    check({tag, "_tx_data"},     32'(tx_data),     32'd0);
    check({tag, "_active"},      32'(active),      32'd0);
    check({tag, "_ack_error"},   32'(ack_error),   32'd0);
    check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[3];
    int   n, rd_c, st_c, id_c, r0, s0, e0;

    vecs[0] = '{8'hA5, 3, 2, 3, 3 + G_CYC + 2};
    vecs[1] = '{8'h00, 1, 2, 3, 1 + G_CYC + 2};
    vecs[2] = '{8'hFF, 5, 2, 3, 5 + G_CYC + 2};

    reset = 1'b0; enable = 1'b0; clear_err = 1'b0;
    fifo_empty = 1'b1; fifo_data = '0; tx_busy = 1'b0;
    #2;
    check_reset_outputs("por");
    tick(); tick();
    reset = 1'b1;
    enable = 1'b1;
    tick(); tick();
    check("idle_when_empty", 32'(active), 32'd0);

    // Latency vectors: byte becomes visible in cycle n.
    foreach (vecs[i]) begin
      busy_len = vecs[i].busy_len;
      push(vecs[i].data);
      n = cyc + 1;
      rd_c = -1; st_c = -1; id_c = -1;
      r0 = rd_count;
      for (int k = 0; k < 100 && id_c < 0; k++) begin
        tick();
        if (fifo_rd && rd_c < 0) rd_c = cyc;
        if (tx_start && st_c < 0) st_c = cyc;
        if (st_c >= 0 && !active) id_c = cyc;
      end
      check($sformatf("vec%0d_rd_latency", i),    32'(rd_c - n),    32'(vecs[i].exp_rd_off));
      check($sformatf("vec%0d_start_latency", i), 32'(st_c - n),    32'(vecs[i].exp_start_off));
      check($sformatf("vec%0d_idle_after", i),    32'(id_c - st_c), 32'(vecs[i].exp_idle_off));
      check($sformatf("vec%0d_pops", i),          32'(rd_count - r0), 32'd1);
      exp_frames++;
      check($sformatf("vec%0d_frame_count", i), 32'(frame_count), 32'(exp_frames % 16));
    end

    // Ack timeout: ack_error is set on the edge ACK_TIMEOUT clocks after the transmitter captures tx_start.
    busy_en = 1'b0;
    push(8'h5A);
    wait_start("timeout1_no_start");
    s0 = last_start;
    e0 = -1;
    for (int k = 0; k < 50 && e0 < 0; k++) begin
      tick();
      if (ack_error) e0 = cyc;
    end
    check("timeout1_delay", 32'(e0 - s0), 32'(A_TO + 1));
    check("timeout1_frame_count", 32'(frame_count), 32'(exp_frames % 16));
    run_frames(start_count, 100, "timeout1_idle");
    clear_err = 1'b1; tick(); clear_err = 1'b0; tick();
    check("clear_err", 32'(ack_error), 32'd0);

    // Timeout while clear_err is held: set wins.
    push(8'hC3);
    wait_start("timeout2_no_start");
    s0 = last_start;
    clear_err = 1'b1;
    e0 = -1;
    for (int k = 0; k < 50 && e0 < 0; k++) begin
      tick();
      if (ack_error) e0 = cyc;
    end
    clear_err = 1'b0;
    check("timeout2_set_wins_delay", 32'(e0 - s0), 32'(A_TO + 1));
    tick();
    check("timeout2_sticky", 32'(ack_error), 32'd1);
    run_frames(start_count, 100, "timeout2_idle");
    busy_en = 1'b1;
    busy_len = 2;
    push(8'h77);
    run_frames(start_count + 1, 100, "after_timeout_frame");
    exp_frames++;
    check("after_timeout_frame_count", 32'(frame_count), 32'(exp_frames % 16));
    check("after_timeout_error_kept", 32'(ack_error), 32'd1);
    clear_err = 1'b1; tick(); clear_err = 1'b0;

    // Enable drop one cycle after tx_start with 3 bytes queued.
    push(8'h11); push(8'h22); push(8'h33);
    wait_start("enable_drop_no_start");
    tick();
    enable = 1'b0;
    r0 = rd_count;
    s0 = start_count;
    for (int k = 0; k < 60; k++) tick();
    exp_frames++;
    check("enable_drop_no_pop", 32'(rd_count - r0), 32'd0);
    check("enable_drop_no_start", 32'(start_count - s0), 32'd0);
    check("enable_drop_idle", 32'(active), 32'd0);
    check("enable_drop_frame_count", 32'(frame_count), 32'(exp_frames % 16));
    enable = 1'b1;
    run_frames(s0 + 2, 200, "reenable_frames");
    exp_frames += 2;
    check("reenable_pops", 32'(rd_count - r0), 32'd2);
    check("reenable_frame_count", 32'(frame_count), 32'(exp_frames % 16));
    check("reenable_empty", 32'(fifo_empty), 32'd1);

    // Asynchronous reset during WAIT_DONE.
    busy_len = 10;
    push(8'h3C);
    wait_start("reset_mid_no_start");
    tick(); tick(); tick();
    push(8'h44); push(8'h55);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    tick(); tick();
    busy_len = 1;
    reset = 1'b1;
    n = cyc;
    rd_c = -1; st_c = -1;
    for (int k = 0; k < 20 && st_c < 0; k++) begin
      tick();
      if (fifo_rd && rd_c < 0) rd_c = cyc;
      if (tx_start && st_c < 0) st_c = cyc;
    end
    check("post_reset_rd_latency", 32'(rd_c - n), 32'd2);
    check("post_reset_start_latency", 32'(st_c - n), 32'd3);
    run_frames(start_count + 1, 100, "post_reset_frames");
    exp_frames = 2;
    check("post_reset_frame_count", 32'(frame_count), 32'(exp_frames));

    // Full-FIFO burst, then one more frame to wrap the 4-bit counter to 1.
    reset = 1'b0; tick(); reset = 1'b1; tick();
    busy_len = 1;
    r0 = rd_count;
    s0 = start_count;
    for (int i = 1; i <= 16; i++) push(DW'(i));
    run_frames(s0 + 16, 1000, "burst_frames");
    check("burst_pops", 32'(rd_count - r0), 32'd16);
    check("burst_frame_count", 32'(frame_count), 32'd0);
    check("burst_fifo_empty", 32'(fifo_empty), 32'd1);
    check("burst_scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("burst_spacing", 32'(last_start - prev_start), 32'(4 + busy_len + G_CYC + 1));
    for (int k = 0; k < 10; k++) tick();
    check("burst_no_extra_pop", 32'(rd_count - r0), 32'd16);
    push(8'hEE);
    run_frames(s0 + 17, 100, "wrap_frame");
    check("wrap_frame_count", 32'(frame_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
